// File: rtl/systolic_result_deskew.sv
// systolic_result_deskew: per-column FWFT FIFOs realigning skewed array results into whole rows
module systolic_result_deskew #(
  parameter int N_COLS = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ROWS   = 4,
  localparam int RW    = ROWS > 1 ? $clog2(ROWS) : 1
) (
  input  logic                       clock_i,
  input  logic                       resetn_i,
  input  logic                       clear_i,
  input  logic [N_COLS-1:0]          col_valid_i,
  input  logic [N_COLS*DATA_W-1:0]   col_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [N_COLS*DATA_W-1:0]   out_data_o,
  output logic                       out_last_o,
  output logic                       overflow_o,
  output logic [RW-1:0]              row_idx_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [N_COLS-1:0] w_nonempty;
  logic [N_COLS-1:0] w_drop;
  logic              w_pop;
  logic [RW-1:0]     r_row;
  logic              r_ovf;
  assign out_valid_o = &w_nonempty && !clear_i;
  assign w_pop       = out_valid_o && out_ready_i;
  assign out_last_o  = (r_row == RW'(ROWS - 1)) && out_valid_o;
  assign row_idx_o   = r_row;
  assign overflow_o  = r_ovf;
  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [CW-1:0]     r_cnt;
    logic              w_full;
    logic              w_push;
    assign w_full        = r_cnt == CW'(DEPTH);
    // a full FIFO still accepts a write when the row is popped on the same edge
    assign w_push        = col_valid_i[c] && (!w_full || w_pop);
    assign w_drop[c]     = col_valid_i[c] && w_full && !w_pop;
    assign w_nonempty[c] = r_cnt != '0;
    assign out_data_o[c*DATA_W +: DATA_W] = r_mem[r_rp];
    always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (clear_i) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wp] <= col_data_i[c*DATA_W +: DATA_W];
          r_wp        <= r_wp == AW'(DEPTH - 1) ? '0 : r_wp + AW'(1);
        end
        if (w_pop) r_rp <= r_rp == AW'(DEPTH - 1) ? '0 : r_rp + AW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_row <= '0;
      r_ovf <= 1'b0;
    end else if (clear_i) begin
      r_row <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_pop) r_row <= r_row == RW'(ROWS - 1) ? '0 : r_row + RW'(1);
      if (|w_drop) r_ovf <= 1'b1;
    end
  end
endmodule
